// File: rtl/vera_mem_pkg.sv
// Shared types and helpers for the VERA-style memory blocks: clear-FSM state
// encoding, default lane width and the byte-enable to bit-mask expansion.
package vera_mem_pkg;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_BUSY = 1'b1
    } clr_state_t;

    localparam int DEFAULT_BYTE_WIDTH = 8;
    localparam int MAX_DATA_WIDTH     = 1024;

    // Expand one enable bit per lane into one mask bit per data bit; callers
    // cast the result down to their own DATA_WIDTH.
    function automatic logic [MAX_DATA_WIDTH-1:0] lane_mask(
        input logic [MAX_DATA_WIDTH-1:0] be,
        input int                        byte_width,
        input int                        data_width
    );
        logic [MAX_DATA_WIDTH-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
            if (i < data_width) begin
                mask[i] = be[i / byte_width];
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/dpram_be_core.sv
// Bare simple dual-port array: byte-lane write, registered read (old data on
// a same-address collision) so synthesis maps it onto block RAM.
module dpram_be_core #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    localparam int NB        = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [NB-1:0]         wbe_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [0:(1 << ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe_i[i]) begin
                    mem_q[waddr_i][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_i[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Output register with synchronous reset maps to the RAM's own output latch reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dpram_be_clr.sv
// Byte-enable dual-port RAM with write-to-read forwarding and a hardware clear
// sequencer. Optional second read stage: define DPRAM_BE_CLR_OUTREG_EN.
module dpram_be_clr
    import vera_mem_pkg::*;
#(
    parameter int                   ADDR_WIDTH  = 8,
    parameter int                   DATA_WIDTH  = 32,
    parameter int                   BYTE_WIDTH  = DEFAULT_BYTE_WIDTH,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
    localparam int                  NB          = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_req,
    output logic                  busy,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [NB-1:0]         wr_be,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output clr_state_t            dbg_state
);

    // Handshake: no back-pressure. An access is accepted in any cycle where its
    // enable is high and busy is low; an accepted read yields exactly one
    // rd_valid pulse after the read latency, with rd_data valid in that cycle.

    clr_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLR_BUSY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CLR_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = CLR_IDLE;
                end
            end
            default: ;
        endcase
        // A request restarts the sweep from word 0 whatever the current state.
        if (clr_req) begin
            state_d = CLR_BUSY;
            cnt_d   = '0;
        end
    end

    assign busy      = (state_q == CLR_BUSY);
    assign dbg_state = state_q;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [NB-1:0]         mem_wbe;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  rd_fire;

    assign mem_we    = busy | wr_en;
    assign mem_waddr = busy ? cnt_q : wr_addr;
    assign mem_wbe   = busy ? '1 : wr_be;
    assign mem_wdata = busy ? CLEAR_VALUE : wr_data;
    assign rd_fire   = rd_en & ~busy;

    dpram_be_core #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_core (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wbe_i   (mem_wbe),
        .wdata_i (mem_wdata),
        .re_i    (rd_fire),
        .raddr_i (rd_addr),
        .rdata_o (mem_rdata)
    );

    // The array returns pre-write contents on a collision, so the lanes written
    // in the read cycle are captured here and patched over the array output.
    logic [DATA_WIDTH-1:0] wr_mask;
    logic [DATA_WIDTH-1:0] fwd_mask_q;
    logic [DATA_WIDTH-1:0] fwd_data_q;
    logic                  s1_valid_q;
    logic [DATA_WIDTH-1:0] s1_data;

    assign wr_mask = DATA_WIDTH'(lane_mask(MAX_DATA_WIDTH'(wr_be), BYTE_WIDTH, DATA_WIDTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            fwd_mask_q <= '0;
            fwd_data_q <= '0;
        end else begin
            s1_valid_q <= rd_fire;
            if (rd_fire) begin
                fwd_mask_q <= (wr_en && (wr_addr == rd_addr)) ? wr_mask : '0;
                fwd_data_q <= wr_data;
            end
        end
    end

    assign s1_data = (mem_rdata & ~fwd_mask_q) | (fwd_data_q & fwd_mask_q);

`ifdef DPRAM_BE_CLR_OUTREG_EN
    logic                  s2_valid_q;
    logic [DATA_WIDTH-1:0] s2_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q <= s1_data;
            end
        end
    end

    assign rd_valid = s2_valid_q;
    assign rd_data  = s2_data_q;
`else
    assign rd_valid = s1_valid_q;
    assign rd_data  = s1_data;
`endif

endmodule

// File: tb/tb_dpram_be_clr.sv
// Self-checking bench for dpram_be_clr (ADDR_WIDTH=4) against a word-array
// reference model; follows DPRAM_BE_CLR_OUTREG_EN for the read latency.
module tb_dpram_be_clr;
    import vera_mem_pkg::*;

    localparam int          AW  = 4;
    localparam int          DW  = 32;
    localparam int          NW  = 1 << AW;
    localparam logic [31:0] CLR = 32'hDEAD_0001;
`ifdef DPRAM_BE_CLR_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          clr_req;
    logic          busy;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_be;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    clr_state_t    dbg_state;

    dpram_be_clr #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .BYTE_WIDTH  (8),
        .CLEAR_VALUE (CLR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr_req   (clr_req),
        .busy      (busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_be     (wr_be),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard / reference model ----------------
    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [NW];
    logic        busy_m    = 1'b1;
    int          left_m    = 0;
    logic        model_ok  = 1'b0;
    logic [31:0] exp_q [$];
    logic        vhist [LAT];
    logic [31:0] dhist [LAT];
    logic        exp_valid = 1'b0;
    logic [31:0] exp_data  = 32'd0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Memory is only observable once a clear finishes, so the model wipes the
    // whole array at that moment; a read sees the word after the same-cycle write.
    function automatic void model_edge();
        logic        fire;
        logic [31:0] rv;
        fire = 1'b0;
        rv   = 32'd0;
        if (rst) begin
            busy_m    = 1'b1;
            left_m    = NW;
            model_ok  = 1'b1;
            exp_valid = 1'b0;
            exp_data  = 32'd0;
            for (int s = 0; s < LAT; s++) begin
                vhist[s] = 1'b0;
                dhist[s] = 32'd0;
            end
            return;
        end
        if (!model_ok) return;
        if (!busy_m) begin
            if (wr_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_be[b]) mem_m[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
                end
            end
            if (rd_en) begin
                fire = 1'b1;
                rv   = mem_m[rd_addr];
            end
        end
        if (clr_req) begin
            busy_m = 1'b1;
            left_m = NW;
        end else if (busy_m) begin
            left_m--;
            if (left_m == 0) begin
                busy_m = 1'b0;
                foreach (mem_m[i]) mem_m[i] = CLR;
            end
        end
        for (int s = LAT - 1; s > 0; s--) begin
            vhist[s] = vhist[s-1];
            dhist[s] = dhist[s-1];
        end
        vhist[0] = fire;
        dhist[0] = rv;
        if (fire) exp_q.push_back(rv);
        exp_valid = vhist[LAT-1];
        if (exp_valid) begin
            exp_data = dhist[LAT-1];
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
    endfunction

    // Single compare point: one clock edge, then all outputs on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (model_ok) begin
            check("busy", 32'(busy), 32'(busy_m));
            check("rd_valid", 32'(rd_valid), 32'(exp_valid));
            check("rd_data", rd_data, exp_data);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [31:0] wd,
                         input logic [3:0] be, input logic r, input logic [AW-1:0] ra,
                         input logic c);
        wr_en   = w;
        wr_addr = wa;
        wr_data = wd;
        wr_be   = be;
        rd_en   = r;
        rd_addr = ra;
        clr_req = c;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic count_busy(input logic wr_busy, output int n);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            drive(wr_busy, 4'd9, 32'hBAD0_BAD0, 4'hF, 1'b0, 4'd0, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        foreach (mem_m[i]) mem_m[i] = CLR;
        rst = 1'b1; clr_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_be = '0;
        wr_data = '0; rd_en = 1'b0; rd_addr = '0;

        // Reset, then a full 16-cycle clear.
        step();
        rst = 1'b0;
        count_busy(1'b0, n);
        check("t1_busy_len", n, 32'd16);
        check("t1_state", 32'(dbg_state), 32'(CLR_IDLE));
        for (int i = 0; i < NW; i++) drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'(i), 1'b0);
        idle(LAT - 1);
        check("t1_last_word", rd_data, CLR);

        // Partial-lane rewrite.
        drive(1'b1, 4'd3, 32'hAABB_CCDD, 4'b1111, 1'b0, 4'd0, 1'b0);
        drive(1'b1, 4'd3, 32'h1122_3344, 4'b0101, 1'b0, 4'd0, 1'b0);
        drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd3, 1'b0);
        idle(LAT - 1);
        check("t2_valid", 32'(rd_valid), 32'd1);
        check("t2_data", rd_data, 32'hAA22_CC44);

        // Same-cycle write/read forwarding, lanes 0-1 new.
        drive(1'b1, 4'd5, 32'h1234_5678, 4'b1111, 1'b0, 4'd0, 1'b0);
        drive(1'b1, 4'd5, 32'hFFFF_FFFF, 4'b0011, 1'b1, 4'd5, 1'b0);
        idle(LAT - 1);
        check("t3_valid", 32'(rd_valid), 32'd1);
        check("t3_data", rd_data, 32'h1234_FFFF);
        idle(1);
        check("t3_valid_drop", 32'(rd_valid), 32'd0);

        // Reads during busy are dropped; rd_data holds.
        drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'(k), 1'b0);
            check("t5_no_valid", 32'(rd_valid), 32'd0);
            check("t5_hold", rd_data, 32'h1234_FFFF);
        end
        count_busy(1'b0, n);
        check("t5_busy_rest", n, 32'd11);

        // Clear restart at count 7, with writes attempted while busy.
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(7);
        drive(1'b1, 4'd9, 32'h5555_AAAA, 4'hF, 1'b0, 4'd0, 1'b1);
        count_busy(1'b1, n);
        check("t4_busy_len", n, 32'd16);
        drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd9, 1'b0);
        idle(LAT - 1);
        check("t4_word9", rd_data, CLR);

`ifdef DPRAM_BE_CLR_OUTREG_EN
        drive(1'b1, 4'd2, 32'h0000_005A, 4'hF, 1'b0, 4'd0, 1'b0);
        drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd2, 1'b0);
        check("t6_gap", 32'(rd_valid), 32'd0);
        idle(1);
        check("t6_valid", 32'(rd_valid), 32'd1);
        check("t6_data", rd_data, 32'h0000_005A);
        drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd2, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("t6_rst_drop", 32'(rd_valid), 32'd0);
        check("t6_rst_data", rd_data, 32'd0);
        count_busy(1'b0, n);
`endif

        // Randomised traffic with occasional clear requests and resets.
        for (int k = 0; k < 2000; k++) begin
            logic [AW-1:0] wa;
            wa  = AW'($urandom_range(0, NW - 1));
            rst = ($urandom_range(0, 399) == 0);
            drive(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, NW - 1)),
                  ($urandom_range(0, 149) == 0));
        end
        rst = 1'b0;
        idle(LAT + 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
